// File: rtl/oh_padcfg_ctrl_if.sv
// ----------------------------------------------------------------------------
// oh_padcfg_ctrl_if
// Request/response port of the pad configuration controller.
//   req_valid/req_ready  : request handshake, accepted when both are high
//   req_cmd              : 00 WR_SHADOW, 01 RD_SHADOW, 10 RD_ACTIVE, 11 COMMIT
//   req_addr             : [6:5] side (0 no, 1 ea, 2 so, 3 we), [4:0] pad index
//   req_wdata            : shadow write data
//   rsp_valid            : one-cycle response strobe
//   rsp_data / rsp_err   : read data / pad index out of range
//   busy                 : commit in progress
// master = control fabric side, slave = controller side.
// ----------------------------------------------------------------------------
interface oh_padcfg_ctrl_if #(
    parameter int CFGW = 8
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_cmd;
    logic [6:0]      req_addr;
    logic [CFGW-1:0] req_wdata;
    logic            rsp_valid;
    logic [CFGW-1:0] rsp_data;
    logic            rsp_err;
    logic            busy;

    modport master (
        output req_valid, req_cmd, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/oh_padcfg_ctrl.sv
// ----------------------------------------------------------------------------
// oh_padcfg_ctrl
// Per-pad configuration controller for the four-sided GPIO padring.
// Software stages cfg words in shadow registers; COMMIT copies shadow to
// active one side at a time (no, ea, so, we) with STAGGER idle cycles between
// sides to limit simultaneous I/O switching.
// Ports:
//   clk, nreset            clock, synchronous active-low reset
//   bus (slave)            request/response port, see oh_padcfg_ctrl_if
//   no/ea/so/we_cfg        active cfg per side, pad i at [i*CFGW +: CFGW]
// ----------------------------------------------------------------------------
module oh_padcfg_ctrl #(
    parameter int              NO_GPIO     = 9,
    parameter int              EA_GPIO     = 9,
    parameter int              SO_GPIO     = 9,
    parameter int              WE_GPIO     = 9,
    parameter int              CFGW        = 8,
    parameter logic [CFGW-1:0] DEFAULT_CFG = '0,
    parameter int              STAGGER     = 0
) (
    input  logic                    clk,
    input  logic                    nreset,
    oh_padcfg_ctrl_if.slave         bus,
    output logic [NO_GPIO*CFGW-1:0] no_cfg,
    output logic [EA_GPIO*CFGW-1:0] ea_cfg,
    output logic [SO_GPIO*CFGW-1:0] so_cfg,
    output logic [WE_GPIO*CFGW-1:0] we_cfg
);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT} state_e;
    typedef enum logic [1:0] {
        CMD_WR_SHADOW = 2'b00,
        CMD_RD_SHADOW = 2'b01,
        CMD_RD_ACTIVE = 2'b10,
        CMD_COMMIT    = 2'b11
    } cmd_e;

    function automatic int side_cnt(input int side);
        case (side)
            0:       return NO_GPIO;
            1:       return EA_GPIO;
            2:       return SO_GPIO;
            default: return WE_GPIO;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      side_q, side_d;     // side loaded while in S_APPLY
    logic [3:0]      wait_q, wait_d;     // stagger cycles still to sit in S_WAIT
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [CFGW-1:0] rsp_data_q, rsp_data_d;
    logic            busy_q, busy_d;

    cmd_e            cmd;
    logic [1:0]      req_side;
    logic [4:0]      req_pad;
    logic            accept;
    logic            in_range;
    logic            wr_en;
    logic            load_en;
    logic [CFGW-1:0] rd_shadow [4];
    logic [CFGW-1:0] rd_active [4];

    assign cmd      = cmd_e'(bus.req_cmd);
    assign req_side = bus.req_addr[6:5];
    assign req_pad  = bus.req_addr[4:0];
    assign accept   = bus.req_valid & ~busy_q;
    assign in_range = int'(req_pad) < side_cnt(int'(req_side));

    // Next-state logic.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        side_d  = side_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && cmd == CMD_COMMIT) begin
                    state_d = S_APPLY;
                    side_d  = '0;
                end
            end
            S_APPLY: begin
                if (side_q == 2'd3) begin
                    state_d = S_IDLE;
                end else begin
                    side_d = side_q + 2'd1;
                    if (STAGGER == 0) begin
                        state_d = S_APPLY;
                    end else begin
                        // S_WAIT is left on the cycle the counter reads zero,
                        // giving exactly STAGGER idle edges between loads.
                        state_d = S_WAIT;
                        wait_d  = 4'(STAGGER - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) state_d = S_APPLY;
                else                wait_d  = wait_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath control.
    always_comb begin
        wr_en       = 1'b0;
        load_en     = (state_q == S_APPLY);
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        busy_d      = (state_d != S_IDLE);
        if (accept && cmd != CMD_COMMIT) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ~in_range;
            if (in_range) begin
                case (cmd)
                    CMD_WR_SHADOW: wr_en      = 1'b1;
                    CMD_RD_SHADOW: rsp_data_d = rd_shadow[req_side];
                    CMD_RD_ACTIVE: rsp_data_d = rd_active[req_side];
                    default:       ;
                endcase
            end
        end
        if (state_q == S_APPLY && side_q == 2'd3) rsp_valid_d = 1'b1;
    end

    // Control registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!nreset) begin
            state_q     <= S_IDLE;
            side_q      <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            side_q      <= side_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    // Per-side shadow/active storage, sized to the side's pad count.
    for (genvar k = 0; k < 4; k++) begin : g_side
        localparam int N = side_cnt(k);

        logic [N*CFGW-1:0] shadow_q, shadow_d;
        logic [N*CFGW-1:0] active_q, active_d;
        logic [CFGW-1:0]   shadow_rd, active_rd;

        always_comb begin
            shadow_d  = shadow_q;
            active_d  = active_q;
            shadow_rd = '0;
            active_rd = '0;
            for (int i = 0; i < N; i++) begin
                if (req_pad == 5'(i)) begin
                    shadow_rd = shadow_q[i*CFGW +: CFGW];
                    active_rd = active_q[i*CFGW +: CFGW];
                    if (wr_en && req_side == 2'(k)) shadow_d[i*CFGW +: CFGW] = bus.req_wdata;
                end
            end
            if (load_en && side_q == 2'(k)) active_d = shadow_q;
        end

        always_ff @(posedge clk) begin
            // NOTE: the cfg storage is reset (unlike a plain RAM) because the pads must come up in a known state.
            if (!nreset) begin
                shadow_q <= {N{DEFAULT_CFG}};
                active_q <= {N{DEFAULT_CFG}};
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
            end
        end

        assign rd_shadow[k] = shadow_rd;
        assign rd_active[k] = active_rd;

        if (k == 0) begin : g_no
            assign no_cfg = active_q;
        end else if (k == 1) begin : g_ea
            assign ea_cfg = active_q;
        end else if (k == 2) begin : g_so
            assign so_cfg = active_q;
        end else begin : g_we
            assign we_cfg = active_q;
        end
    end

    assign bus.req_ready = ~busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_oh_padcfg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_oh_padcfg_ctrl
// Two controller instances: dut 0 with STAGGER=2 (main traffic and commits),
// dut 1 with STAGGER=3 (reset in the middle of a commit). A behavioural model
// holds the shadow/active contents as plain arrays; commit timing follows
// "side k lands at E0+1+k*(STAGGER+1)".
// ----------------------------------------------------------------------------
module tb_oh_padcfg_ctrl;
    localparam int CFGW = 8;
    localparam int G    = 9;
    localparam logic [CFGW-1:0] DEF = 8'h00;
    localparam int STG [2] = '{2, 3};

    localparam logic [1:0] C_WR = 2'b00;
    localparam logic [1:0] C_RS = 2'b01;
    localparam logic [1:0] C_RA = 2'b10;
    localparam logic [1:0] C_CM = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nreset_a, nreset_b;
    logic [G*CFGW-1:0] cfg_a [4];
    logic [G*CFGW-1:0] cfg_b [4];

    oh_padcfg_ctrl_if #(.CFGW(CFGW)) bus_a ();
    oh_padcfg_ctrl_if #(.CFGW(CFGW)) bus_b ();

    oh_padcfg_ctrl #(
        .NO_GPIO(G), .EA_GPIO(G), .SO_GPIO(G), .WE_GPIO(G),
        .CFGW(CFGW), .DEFAULT_CFG(DEF), .STAGGER(2)
    ) dut_a (
        .clk(clk), .nreset(nreset_a), .bus(bus_a),
        .no_cfg(cfg_a[0]), .ea_cfg(cfg_a[1]), .so_cfg(cfg_a[2]), .we_cfg(cfg_a[3])
    );

    oh_padcfg_ctrl #(
        .NO_GPIO(G), .EA_GPIO(G), .SO_GPIO(G), .WE_GPIO(G),
        .CFGW(CFGW), .DEFAULT_CFG(DEF), .STAGGER(3)
    ) dut_b (
        .clk(clk), .nreset(nreset_b), .bus(bus_b),
        .no_cfg(cfg_b[0]), .ea_cfg(cfg_b[1]), .so_cfg(cfg_b[2]), .we_cfg(cfg_b[3])
    );

    // Reference model: shadow and active contents per dut/side/pad.
    logic [CFGW-1:0] sh_m  [2][4][G];
    logic [CFGW-1:0] act_m [2][4][G];

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [1:0] cmd,
                         input logic [6:0] addr, input logic [CFGW-1:0] wd);
        if (d == 0) begin
            bus_a.req_valid = v; bus_a.req_cmd = cmd; bus_a.req_addr = addr; bus_a.req_wdata = wd;
        end else begin
            bus_b.req_valid = v; bus_b.req_cmd = cmd; bus_b.req_addr = addr; bus_b.req_wdata = wd;
        end
    endtask

    function automatic logic [127:0] obs_cfg(input int d, input int s);
        return (d == 0) ? 128'(cfg_a[s]) : 128'(cfg_b[s]);
    endfunction
    function automatic logic obs_rv(input int d);
        return (d == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
    endfunction
    function automatic logic obs_err(input int d);
        return (d == 0) ? bus_a.rsp_err : bus_b.rsp_err;
    endfunction
    function automatic logic [CFGW-1:0] obs_data(input int d);
        return (d == 0) ? bus_a.rsp_data : bus_b.rsp_data;
    endfunction
    function automatic logic obs_busy(input int d);
        return (d == 0) ? bus_a.busy : bus_b.busy;
    endfunction
    function automatic logic obs_ready(input int d);
        return (d == 0) ? bus_a.req_ready : bus_b.req_ready;
    endfunction

    function automatic logic [127:0] exp_cfg(input int d, input int s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < G; i++) r[i*CFGW +: CFGW] = act_m[d][s][i];
        return r;
    endfunction

    task automatic model_reset(input int d);
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < G; i++) begin
                sh_m[d][s][i]  = DEF;
                act_m[d][s][i] = DEF;
            end
    endtask

    task automatic check_cfg(input int d, input string tag);
        for (int s = 0; s < 4; s++)
            check($sformatf("%s d%0d cfg side%0d", tag, d, s), obs_cfg(d, s), exp_cfg(d, s));
    endtask

    task automatic check_idle(input int d, input string tag);
        check_cfg(d, tag);
        check($sformatf("%s d%0d busy", tag, d), 128'(obs_busy(d)), 128'(0));
        check($sformatf("%s d%0d req_ready", tag, d), 128'(obs_ready(d)), 128'(1));
        check($sformatf("%s d%0d rsp_valid", tag, d), 128'(obs_rv(d)), 128'(0));
    endtask

    // One accepted non-commit request; req_valid is left high so calls chain back-to-back.
    task automatic req(input int d, input logic [1:0] cmd, input int side, input int pad,
                       input logic [CFGW-1:0] wd);
        logic            in_rng;
        logic [CFGW-1:0] exp_d;
        in_rng = (pad < G);
        exp_d  = '0;
        if (in_rng) begin
            if (cmd == C_RS) exp_d = sh_m[d][side][pad];
            if (cmd == C_RA) exp_d = act_m[d][side][pad];
            if (cmd == C_WR) sh_m[d][side][pad] = wd;
        end
        drive(d, 1'b1, cmd, {2'(side), 5'(pad)}, wd);
        step();
        check($sformatf("d%0d cmd%0d s%0d p%0d rsp_valid", d, cmd, side, pad), 128'(obs_rv(d)), 128'(1));
        check($sformatf("d%0d cmd%0d s%0d p%0d rsp_err", d, cmd, side, pad), 128'(obs_err(d)), 128'(!in_rng));
        check($sformatf("d%0d cmd%0d s%0d p%0d rsp_data", d, cmd, side, pad), 128'(obs_data(d)), 128'(exp_d));
    endtask

    task automatic rand_req(input int d);
        int          pad;
        logic [1:0]  cmd;
        cmd = 2'($urandom_range(0, 2));
        pad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(G, 31)) : int'($urandom_range(0, G - 1));
        req(d, cmd, int'($urandom_range(0, 3)), pad, CFGW'($urandom));
    endtask

    // Full commit; optionally a WR_SHADOW is held on the port throughout.
    task automatic commit(input int d, input bit queue_wr, input int qside, input int qpad,
                          input logic [CFGW-1:0] qwd);
        int s;
        int lat;
        s   = STG[d];
        lat = 4 + 3 * s;
        drive(d, 1'b1, C_CM, 7'($urandom), '0);
        step();  // E0
        check($sformatf("d%0d E0 busy", d), 128'(obs_busy(d)), 128'(1));
        check($sformatf("d%0d E0 req_ready", d), 128'(obs_ready(d)), 128'(0));
        check($sformatf("d%0d E0 rsp_valid", d), 128'(obs_rv(d)), 128'(0));
        if (queue_wr) drive(d, 1'b1, C_WR, {2'(qside), 5'(qpad)}, qwd);
        else          drive(d, 1'b0, C_WR, '0, '0);
        for (int e = 1; e <= lat; e++) begin
            step();
            for (int k = 0; k < 4; k++)
                if (e == 1 + k * (s + 1))
                    for (int i = 0; i < G; i++) act_m[d][k][i] = sh_m[d][k][i];
            check_cfg(d, $sformatf("commit E0+%0d", e));
            check($sformatf("d%0d E0+%0d busy", d, e), 128'(obs_busy(d)), 128'(e < lat));
            check($sformatf("d%0d E0+%0d rsp_valid", d, e), 128'(obs_rv(d)), 128'(e == lat));
        end
        check($sformatf("d%0d commit rsp_err", d), 128'(obs_err(d)), 128'(0));
        check($sformatf("d%0d commit rsp_data", d), 128'(obs_data(d)), 128'(0));
        check($sformatf("d%0d commit done req_ready", d), 128'(obs_ready(d)), 128'(1));
        if (queue_wr) begin
            if (qpad < G) sh_m[d][qside][qpad] = qwd;
            step();
            check($sformatf("d%0d queued wr rsp_valid", d), 128'(obs_rv(d)), 128'(1));
            check($sformatf("d%0d queued wr rsp_err", d), 128'(obs_err(d)), 128'(qpad >= G));
            drive(d, 1'b0, C_WR, '0, '0);
            step();
            check($sformatf("d%0d queued wr single rsp", d), 128'(obs_rv(d)), 128'(0));
            req(d, C_RS, qside, qpad, '0);
            drive(d, 1'b0, C_WR, '0, '0);
        end else begin
            step();
            check($sformatf("d%0d commit rsp one cycle", d), 128'(obs_rv(d)), 128'(0));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive(0, 1'b0, C_WR, '0, '0);
        drive(1, 1'b0, C_WR, '0, '0);
        model_reset(0);
        model_reset(1);
        nreset_a = 1'b0;
        nreset_b = 1'b0;
        repeat (2) step();

        // Reset state of both instances.
        check_idle(0, "reset");
        check_idle(1, "reset");
        nreset_a = 1'b1;
        nreset_b = 1'b1;
        step();

        // Shadow write then reads, back-to-back; active untouched.
        req(0, C_WR, 0, 3, 8'hA5);
        req(0, C_RS, 0, 3, '0);
        req(0, C_RA, 0, 3, '0);
        drive(0, 1'b0, C_WR, '0, '0);
        step();
        check("rsp strobe drops", 128'(obs_rv(0)), 128'(0));
        check_cfg(0, "after wr");

        // Out-of-range pad indices.
        req(0, C_WR, 1, 9, 8'h5A);
        req(0, C_RS, 3, 31, '0);
        req(0, C_RS, 1, 8, '0);
        drive(0, 1'b0, C_WR, '0, '0);
        step();
        check_cfg(0, "after err");

        // Staggered commit of one distinct word per side.
        req(0, C_WR, 0, 0, 8'h11);
        req(0, C_WR, 1, 0, 8'h22);
        req(0, C_WR, 2, 0, 8'h33);
        req(0, C_WR, 3, 0, 8'h44);
        commit(0, 1'b0, 0, 0, '0);

        // Random traffic, commits with a write held on the port, unchanged-shadow commit.
        for (int r = 0; r < 4; r++) begin
            repeat (20) rand_req(0);
            commit(0, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, G - 1)), CFGW'($urandom));
        end
        commit(0, 1'b0, 0, 0, '0);
        for (int i = 0; i < 6; i++) req(0, C_RA, int'($urandom_range(0, 3)), int'($urandom_range(0, G - 1)), '0);
        drive(0, 1'b0, C_WR, '0, '0);

        // Reset in the middle of a STAGGER=3 commit on dut 1.
        for (int k = 0; k < 4; k++) req(1, C_WR, k, 0, CFGW'(8'h11 * (k + 1)));
        repeat (6) rand_req(1);
        drive(1, 1'b1, C_CM, '0, '0);
        step();  // E0
        drive(1, 1'b0, C_WR, '0, '0);
        for (int e = 1; e <= 5; e++) begin
            step();
            for (int k = 0; k < 4; k++)
                if (e == 1 + k * 4)
                    for (int i = 0; i < G; i++) act_m[1][k][i] = sh_m[1][k][i];
            check_cfg(1, $sformatf("pre-abort E0+%0d", e));
        end
        nreset_b = 1'b0;
        step();  // E0+6
        model_reset(1);
        check_idle(1, "abort");
        nreset_b = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            check($sformatf("post-abort +%0d rsp_valid", e), 128'(obs_rv(1)), 128'(0));
            check($sformatf("post-abort +%0d busy", e), 128'(obs_busy(1)), 128'(0));
        end
        check_cfg(1, "post-abort");
        req(1, C_RS, 0, 0, '0);
        req(1, C_RS, 3, 0, '0);
        drive(1, 1'b0, C_WR, '0, '0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
